multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
- Main control FSM for the multicycle CPU, sitting directly upstream of the datapath.
- Consumes the latched instruction word (IReg_out) and sequences FETCH / DECODE / EXECUTE / MEMORY / WRITEBACK.
- Drives every datapath control line each cycle.
- Exposes state, halt, illegal-opcode and retired-instruction count for debug.

Parameters:
- ALU_ADD, 4'b0000, ALUOp code for addition (PC increment, address add).
- ALU_PASSB, 4'b1111, ALUOp code that passes ALU operand B through (used by LUI).
- CNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low reset.
- IReg_out  in  32  instruction register contents; only [31:26] (opcode) are decoded.
- PCWrite  out  1  PC load enable.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  data memory write enable.
- IRWrite  out  1  instruction register load enable.
- MemtoReg  out  1  register write data select: 0 = ALUOut, 1 = MDR.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  ALU operand A select: 0 = PC, 1 = regA.
- ALUSrcB  out  2  ALU operand B select: 00 = regB, 01 = 1, 10 = SE(imm), 11 = ZE(imm).
- ALUOp  out  4  ALU operation code.
- PCSource  out  2  PC source select: 00 = ALU wire, 01 = ALUOut, 10 = jump, 11 = branch.
- BranchType  out  3  branch condition; 000 = none.
- LUI  out  1  register file upper-immediate write mode.
- SWB  out  1  read-select swap, so readsel1 = r1 and readsel2 = r2.
- state  out  4  current FSM state code (debug).
- halted  out  1  high while in HALT.
- illegal_op  out  1  sticky flag, set on any undefined opcode.
- instr_retired  out  CNT_WIDTH  count of completed instructions.

Behaviour:
- Output timing:
  - Outputs are Moore: combinational from state and the opcode IReg_out[31:26].
  - The opcode is stable after FETCH because IRWrite is only asserted in FETCH.
- Reset:
  - While reset=0, state=RST (0), all control outputs are 0, illegal_op=0, instr_retired=0.
  - The first posedge after reset deasserts goes RST->FETCH.
  - Reset asserted mid-instruction aborts immediately and asynchronously to RST; no partial writes occur after the reset edge.
- Opcode map:
  - 000000 NOP.
  - 000001 J.
  - 001111 HALT.
  - 01aaaa R-type: ALUOp=aaaa.
  - 11aaaa I-type: ALUOp=aaaa; ALUSrcB=10 if aaaa[3]=0, ALUSrcB=11 if aaaa[3]=1.
  - 100bbb with bbb!=000 branch: BranchType=bbb.
  - 101000 LW.
  - 101001 SW.
  - 101010 LUI.
  - Any other opcode is illegal: treated as NOP and sets illegal_op.
- States, asserted outputs and transitions (unlisted outputs are 0):
  - FETCH(1): IRWrite, MemRead, PCWrite, ALUSrcA=0, ALUSrcB=01, ALUOp=ALU_ADD, PCSource=00 (PC <= PC+1). Next: DECODE.
  - DECODE(2): SWB=1 if SW or branch; regA/regB load in this cycle.
    - R-type -> EXEC_R. I-type -> EXEC_I. LW -> MEM_RD. SW -> MEM_WR.
    - Branch -> BRANCH. J -> JUMP. LUI -> EXEC_L. HALT -> HALT.
    - NOP or illegal -> FETCH, counted as retired.
  - EXEC_R(3): ALUSrcA=1, ALUSrcB=00, ALUOp=aaaa. Next: WB_ALU.
  - EXEC_I(4): ALUSrcA=1, ALUSrcB per the I-type rule, ALUOp=aaaa. Next: WB_ALU.
  - EXEC_L(5): ALUSrcB=11, ALUOp=ALU_PASSB. Next: WB_LUI.
  - WB_ALU(6): RegWrite, MemtoReg=0, while holding the EXEC_R/EXEC_I ALUSrc/ALUOp values. Next: FETCH.
  - WB_LUI(7): RegWrite, LUI=1, MemtoReg=0. Next: FETCH.
  - MEM_RD(8): MemRead. Next: MEM_WB (the MDR captures on this edge).
  - MEM_WB(9): RegWrite, MemtoReg=1. Next: FETCH.
  - MEM_WR(10): MemWrite, SWB=1. Next: FETCH.
  - BRANCH(11): BranchType=bbb, SWB=1, PCWrite=0.
    - The datapath loads PC <= SE(imm)+PC only when its Branch output is true.
    - The PC used is already incremented. Next: FETCH.
  - JUMP(12): PCWrite, PCSource=10. Next: FETCH.
  - HALT(13): all control outputs 0, halted=1. Stays in HALT until reset.
- Cycle counts per instruction, FETCH included:
  - NOP/illegal: 2.
  - J, branch, SW: 3.
  - R-type, I-type, LUI, LW: 4.
  - HALT: 2 to reach HALT.
- instr_retired:
  - Increments by 1 on the edge leaving the last state of each instruction (the edge returning to FETCH).
  - HALT increments once on entry.
  - Wraps modulo 2^CNT_WIDTH.
- illegal_op: set on the DECODE edge of an undefined opcode; cleared only by reset.
- Unused state codes (0xE, 0xF): next state is FETCH, all outputs 0.

Test Plan:
- Reset held low 3 cycles, then released -> outputs all 0 and state=0 during reset; state=1 with IRWrite=PCWrite=1 on the first cycle after release.
- R-type 010010 -> state sequence 1,2,3,6,1; EXEC_R drives ALUOp=0010, ALUSrcA=1, ALUSrcB=00; RegWrite=1 only in WB_ALU; instr_retired 0->1.
- I-type 111001 then 110001 -> ALUSrcB=11 for the first, 10 for the second; both take 4 cycles.
- LW 101000, then SW 101001 -> LW: 1,2,8,9 with MemtoReg=1 in state 9. SW: 1,2,10 with MemWrite=1 and SWB=1 in states 2 and 10. instr_retired=2.
- BEQ 100001, then J 000001 -> branch state drives BranchType=001, PCWrite=0; jump state drives PCSource=10, PCWrite=1; each takes 3 cycles.
- Opcode 000111, then HALT, then reset pulled low mid-HALT -> illegal_op=1 after DECODE of 000111; halted=1 persists 20 cycles; reset immediately returns state=0 and clears illegal_op and instr_retired.

Source files
------------

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle CPU.
// Sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK from the latched opcode
// and drives every datapath control line as a Moore function of
// (state, opcode). Also keeps debug state: halt, a sticky illegal-opcode
// flag and a retired-instruction counter.
module multicycle_controller #(
    parameter logic [3:0] ALU_ADD   = 4'b0000,
    parameter logic [3:0] ALU_PASSB = 4'b1111,
    parameter int         CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          IReg_out,
    output logic                 PCWrite,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 MemtoReg,
    output logic                 RegWrite,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [3:0]           ALUOp,
    output logic [1:0]           PCSource,
    output logic [2:0]           BranchType,
    output logic                 LUI,
    output logic                 SWB,
    output logic [3:0]           state,
    output logic                 halted,
    output logic                 illegal_op,
    output logic [CNT_WIDTH-1:0] instr_retired
);

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_EXEC_I = 4'd4,
        S_EXEC_L = 4'd5,
        S_WB_ALU = 4'd6,
        S_WB_LUI = 4'd7,
        S_MEM_RD = 4'd8,
        S_MEM_WB = 4'd9,
        S_MEM_WR = 4'd10,
        S_BRANCH = 4'd11,
        S_JUMP   = 4'd12,
        S_HALT   = 4'd13
    } state_e;

    state_e               state_q, state_d;
    logic                 illegal_q, illegal_d;
    logic [CNT_WIDTH-1:0] retired_q, retired_d;

    // Opcode classification
    logic [5:0] op;
    logic       is_nop, is_j, is_halt, is_r, is_i, is_br;
    logic       is_lw, is_sw, is_lui, is_ill;

    // Only the opcode field is decoded; the rest belongs to the datapath.
    logic unused_ir_bits;
    assign unused_ir_bits = ^IReg_out[25:0];

    // Decode the opcode field into instruction classes.
    always_comb begin
        op      = IReg_out[31:26];
        is_nop  = (op == 6'b000000);
        is_j    = (op == 6'b000001);
        is_halt = (op == 6'b001111);
        is_r    = (op[5:4] == 2'b01);
        is_i    = (op[5:4] == 2'b11);
        is_br   = (op[5:3] == 3'b100) && (op[2:0] != 3'b000);
        is_lw   = (op == 6'b101000);
        is_sw   = (op == 6'b101001);
        is_lui  = (op == 6'b101010);
        is_ill  = !(is_nop || is_j || is_halt || is_r || is_i || is_br ||
                    is_lw || is_sw || is_lui);
    end

    // Next-state, Moore outputs and debug-counter next values.
    always_comb begin
        state_d    = S_FETCH;
        illegal_d  = illegal_q;
        retired_d  = retired_q;
        PCWrite    = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUOp      = 4'b0000;
        PCSource   = 2'b00;
        BranchType = 3'b000;
        LUI        = 1'b0;
        SWB        = 1'b0;
        halted     = 1'b0;

        case (state_q)
            S_RST: state_d = S_FETCH;

            // PC <= PC + 1 through the ALU while the IR loads.
            S_FETCH: begin
                IRWrite = 1'b1;
                MemRead = 1'b1;
                PCWrite = 1'b1;
                ALUSrcB = 2'b01;
                ALUOp   = ALU_ADD;
                state_d = S_DECODE;
            end

            // Register operands are read here; SW and branches need r1/r2
            // swapped onto the read ports so regB holds the second source.
            S_DECODE: begin
                SWB = is_sw || is_br;
                if (is_r)         state_d = S_EXEC_R;
                else if (is_i)    state_d = S_EXEC_I;
                else if (is_lw)   state_d = S_MEM_RD;
                else if (is_sw)   state_d = S_MEM_WR;
                else if (is_br)   state_d = S_BRANCH;
                else if (is_j)    state_d = S_JUMP;
                else if (is_lui)  state_d = S_EXEC_L;
                else if (is_halt) state_d = S_HALT;
                else              state_d = S_FETCH;
                if (is_ill)
                    illegal_d = 1'b1;
            end

            S_EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b00;
                ALUOp   = op[3:0];
                state_d = S_WB_ALU;
            end

            // aaaa[3] picks zero- vs sign-extension of the immediate.
            S_EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = op[3] ? 2'b11 : 2'b10;
                ALUOp   = op[3:0];
                state_d = S_WB_ALU;
            end

            S_EXEC_L: begin
                ALUSrcB = 2'b11;
                ALUOp   = ALU_PASSB;
                state_d = S_WB_LUI;
            end

            // ALU inputs are held so the write data stays valid all cycle.
            S_WB_ALU: begin
                RegWrite = 1'b1;
                ALUSrcA  = 1'b1;
                ALUOp    = op[3:0];
                if (is_i)
                    ALUSrcB = op[3] ? 2'b11 : 2'b10;
                state_d  = S_FETCH;
            end

            S_WB_LUI: begin
                RegWrite = 1'b1;
                LUI      = 1'b1;
                state_d  = S_FETCH;
            end

            S_MEM_RD: begin
                MemRead = 1'b1;
                state_d = S_MEM_WB;
            end

            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                state_d  = S_FETCH;
            end

            S_MEM_WR: begin
                MemWrite = 1'b1;
                SWB      = 1'b1;
                state_d  = S_FETCH;
            end

            // The datapath qualifies the PC load with its own Branch flag.
            S_BRANCH: begin
                BranchType = op[2:0];
                SWB        = 1'b1;
                state_d    = S_FETCH;
            end

            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                state_d  = S_FETCH;
            end

            S_HALT: begin
                halted  = 1'b1;
                state_d = S_HALT;
            end

            // Unreachable codes recover to FETCH without retiring anything.
            default: state_d = S_FETCH;
        endcase

        // An instruction retires on the edge back to FETCH from any
        // in-flight state, and HALT retires on its entry edge.
        if ((state_d == S_FETCH && state_q inside {[S_DECODE:S_JUMP]}) ||
            (state_d == S_HALT && state_q == S_DECODE))
            retired_d = retired_q + 1'b1;
    end

    // State and debug registers; reset aborts the instruction immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_RST;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    assign state         = state_q;
    assign illegal_op    = illegal_q;
    assign instr_retired = retired_q;

endmodule
